l4_seq: RTL and testbench
=========================

L4_SEQ -- requirements
Module: l4_seq

Interface
REQ-001 Parameter N_IN, default 100, number of input activations fed per inference.
REQ-002 Parameter RDY_TMO, default 255, cycles allowed between last input slot and l4_rdy.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 go  in  1  single-cycle request to run one layer-4 inference; ignored unless in IDLE.
REQ-006 src_rd  out  1  read strobe to previous-layer buffer.
REQ-007 src_addr  out  7  previous-layer buffer address, 0..N_IN-1.
REQ-008 src_rdata  in  18  signed activation, valid the cycle after src_rd.
REQ-009 l4_strt  out  1  start pulse to layer-4 datapath, one per input.
REQ-010 l4_din  out  18  signed activation to layer-4 datapath.
REQ-011 l4_rdy  in  1  layer-4 accumulation complete.
REQ-012 l4_dout  in  18 x 16  layer-4 result group, one group per cycle.
REQ-013 l4_tx_done  out  1  single-cycle pulse clearing layer-4 counters/FSMs.
REQ-014 o_vld, o_rdy  out, in  1, 1  output stream handshake.
REQ-015 o_data, o_idx  out  18, 6  result value and neuron index 0..63.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err  out  1  sticky timeout flag (timeout build only).

Function
REQ-018 FSM states: IDLE, FETCH, LOAD, STRT, BUSY, WAIT_RDY, CAPT, STREAM, DONE.
REQ-019 IDLE -> FETCH on go; input counter cleared to 0.
REQ-020 FETCH: src_rd=1, src_addr=input counter, 1 cycle -> LOAD.
REQ-021 LOAD: l4_din register <= src_rdata, 1 cycle -> STRT.
REQ-022 STRT: l4_strt=1 for exactly one cycle -> BUSY.
REQ-023 BUSY: 4 cycles; then counter+1, -> FETCH if counter < N_IN-1 else WAIT_RDY.
REQ-024 l4_din SHALL hold constant from STRT through last BUSY cycle; one input slot = 7 cycles.
REQ-025 WAIT_RDY: on first cycle l4_rdy=1 -> CAPT.
REQ-026 CAPT: 4 cycles; group g (0..3) = l4_dout[0..15] captured on the (g+1)th cycle after the l4_rdy cycle into buffer entries g*16+n.
REQ-027 STREAM: o_vld=1, o_idx walks 0..63, o_data=buffer[o_idx]; advance only when o_vld and o_rdy both high; o_vld/o_data/o_idx stable while o_rdy=0.
REQ-028 After beat 63 accepted -> DONE; DONE asserts l4_tx_done for one cycle -> IDLE.
REQ-029 go asserted outside IDLE SHALL be ignored with no effect.
REQ-030 l4_strt and l4_tx_done SHALL never be high in the same cycle.
REQ-031 No data arithmetic; o_data is the captured 18-bit value unmodified.

Reset
REQ-032 rst_n low: state=IDLE, counters=0, l4_din=0, all strobes/o_vld/busy/err=0, o_idx=0, o_data=0.
REQ-033 Reset mid-operation aborts immediately; no l4_tx_done issued; capture buffer contents undefined.

Configuration
REQ-034 Macro L4_SEQ_TIMEOUT_EN defined: WAIT_RDY counts cycles; at RDY_TMO cycles without l4_rdy, err sets (sticky until reset) and FSM -> DONE (tx_done pulse, no stream).
REQ-035 L4_SEQ_TIMEOUT_EN undefined: WAIT_RDY waits indefinitely; err tied 0; no timeout counter.

Verification
REQ-036 go, src buffer = ramp 1..100, model l4_rdy at 700 cycles -> exactly 100 l4_strt pulses spaced 7 cycles, l4_din values 1..100 in order.
REQ-037 l4_dout group g lane n = g*16+n, o_rdy=1 -> 64 beats, o_idx 0..63, o_data = o_idx, then one l4_tx_done, busy drops next cycle.
REQ-038 o_rdy toggled 1/0 every cycle in STREAM -> 64 beats total, no drop/duplicate, outputs stable while o_rdy=0.
REQ-039 go pulsed during BUSY and STREAM -> no change in strt count (100) or beat count (64).
REQ-040 rst_n low at input 50 then go -> fresh run starts src_addr=0, no tx_done from aborted run.
REQ-041 L4_SEQ_TIMEOUT_EN, l4_rdy never high -> err=1 after 255 WAIT_RDY cycles, one l4_tx_done, zero o_vld beats.

Source files
------------

// File: rtl/l4_seq.sv
// Layer-4 input sequencer: streams N_IN activations into the layer-4 datapath, captures 64 results, streams them out.
// Optional build macro L4_SEQ_TIMEOUT_EN adds a WAIT_RDY timeout that sets a sticky err and skips the output stream.
module l4_seq #(
    parameter int N_IN    = 100,
    parameter int RDY_TMO = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    output logic             src_rd,
    output logic [6:0]       src_addr,
    input  logic [17:0]      src_rdata,
    output logic             l4_strt,
    output logic [17:0]      l4_din,
    input  logic             l4_rdy,
    input  logic [15:0][17:0] l4_dout,
    output logic             l4_tx_done,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic [17:0]      o_data,
    output logic [5:0]       o_idx,
    output logic             busy,
    output logic             err,
    output logic [3:0]       dbg_state
);

    // Output stream: o_vld/o_data/o_idx are held until a cycle with o_vld && o_rdy, which consumes one beat.
    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, STRT, BUSY, WAIT_RDY, CAPT, STREAM, DONE
    } state_t;

    localparam logic [6:0] LAST_IN = 7'(N_IN - 1);

    state_t      state;
    logic [6:0]  in_cnt;
    logic [1:0]  sub_cnt;     // BUSY cycle count, then CAPT group index
    logic [17:0] cap_buf [64];

    assign dbg_state = state;

`ifdef L4_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(RDY_TMO + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign err = 1'b0;
`endif

    // Capture buffer has no reset: its contents are only read after a full CAPT.
    always_ff @(posedge clk) begin
        if (state == CAPT) begin
            for (int n = 0; n < 16; n++) begin
                cap_buf[{sub_cnt, 4'(n)}] <= l4_dout[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_cnt     <= '0;
            sub_cnt    <= '0;
            src_rd     <= 1'b0;
            src_addr   <= '0;
            l4_strt    <= 1'b0;
            l4_din     <= '0;
            l4_tx_done <= 1'b0;
            o_vld      <= 1'b0;
            o_data     <= '0;
            o_idx      <= '0;
            busy       <= 1'b0;
`ifdef L4_SEQ_TIMEOUT_EN
            tmo_cnt    <= '0;
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= FETCH;
                        in_cnt   <= '0;
                        src_addr <= '0;
                        src_rd   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    src_rd <= 1'b0;
                    state  <= LOAD;
                end
                LOAD: begin
                    l4_din  <= src_rdata;
                    l4_strt <= 1'b1;
                    state   <= STRT;
                end
                STRT: begin
                    l4_strt <= 1'b0;
                    sub_cnt <= '0;
                    state   <= BUSY;
                end
                BUSY: begin
                    sub_cnt <= sub_cnt + 2'd1;
                    if (sub_cnt == 2'd3) begin
                        in_cnt <= in_cnt + 7'd1;
                        if (in_cnt < LAST_IN) begin
                            src_addr <= in_cnt + 7'd1;
                            src_rd   <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            state <= WAIT_RDY;
`ifdef L4_SEQ_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end
                end
                WAIT_RDY: begin
                    if (l4_rdy) begin
                        sub_cnt <= '0;
                        state   <= CAPT;
                    end
`ifdef L4_SEQ_TIMEOUT_EN
                    else if (tmo_cnt == TW'(RDY_TMO - 1)) begin
                        err        <= 1'b1;
                        l4_tx_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                CAPT: begin
                    sub_cnt <= sub_cnt + 2'd1;
                    if (sub_cnt == 2'd3) begin
                        // Group 0 is already stored, so entry 0 is safe to present now.
                        o_vld  <= 1'b1;
                        o_idx  <= '0;
                        o_data <= cap_buf[0];
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (o_rdy) begin
                        if (o_idx == 6'd63) begin
                            o_vld      <= 1'b0;
                            o_idx      <= '0;
                            l4_tx_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            o_idx  <= o_idx + 6'd1;
                            o_data <= cap_buf[o_idx + 6'd1];
                        end
                    end
                end
                DONE: begin
                    l4_tx_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l4_seq.sv
// Bench for l4_seq: cycle-stepped source buffer, layer-4 responder and stream sink around a transaction-level model.
// Define L4_SEQ_TIMEOUT_EN for both files to also exercise the WAIT_RDY timeout.
module tb_l4_seq;
    localparam int N_IN = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              go = 1'b0;
    logic [17:0]       src_rdata = '0;
    logic              l4_rdy = 1'b0;
    logic [15:0][17:0] l4_dout = '0;
    logic              o_rdy = 1'b0;
    logic              src_rd, l4_strt, l4_tx_done, o_vld, busy, err;
    logic [6:0]        src_addr;
    logic [17:0]       l4_din, o_data;
    logic [5:0]        o_idx;
    logic [3:0]        dbg_state;

    int tests = 0;
    int fails = 0;
    logic [17:0] mem [N_IN];
    logic [17:0] res [64];

    l4_seq #(.N_IN(N_IN), .RDY_TMO(255)) dut (
        .clk(clk), .rst_n(rst_n), .go(go),
        .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
        .l4_strt(l4_strt), .l4_din(l4_din), .l4_rdy(l4_rdy), .l4_dout(l4_dout),
        .l4_tx_done(l4_tx_done), .o_vld(o_vld), .o_rdy(o_rdy),
        .o_data(o_data), .o_idx(o_idx), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while reset is (or has just been) applied.
    task automatic chk_reset_outputs();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_src_rd", 32'(src_rd), 0);
        chk("rst_strt", 32'(l4_strt), 0);
        chk("rst_tx_done", 32'(l4_tx_done), 0);
        chk("rst_din", 32'(l4_din), 0);
        chk("rst_vld", 32'(o_vld), 0);
        chk("rst_idx", 32'(o_idx), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_err", 32'(err), 0);
    endtask

    // One inference. rdy_mode: 0 = o_rdy held high, 1 = toggling, 2 = random.
    task automatic run(input int rdy_dly, input int rdy_mode, input bit spam,
                       input int abort_at, input bit ramp, input bit expect_tmo);
        int strt_cnt = 0, last_strt = -100, fetch_cnt = 0, rdy_cyc = -1;
        int beats = 0, tx_cnt = 0, tx_cyc = -1, g;
        bit rd_s = 0, prev_hold = 0, aborted = 0;
        logic [6:0] addr_s = '0;
        logic [17:0] prev_data = '0;
        logic [5:0] prev_idx = '0;

        for (int k = 0; k < N_IN; k++) mem[k] = ramp ? 18'(k + 1) : 18'($urandom);
        for (int k = 0; k < 64; k++) res[k] = ramp ? 18'(k) : 18'($urandom);

        @(posedge clk); #1;
        go = 1'b1;
        o_rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rd_s = src_rd;
            addr_s = src_addr;
            if (src_rd) begin
                chk("src_addr", 32'(src_addr), 32'(fetch_cnt));
                fetch_cnt++;
            end
            if (l4_strt) begin
                if (strt_cnt > 0) chk("strt_gap", 32'(i - last_strt), 7);
                if (strt_cnt < N_IN) chk("l4_din", 32'(l4_din), 32'(mem[strt_cnt]));
                chk("strt_vs_tx", 32'(l4_tx_done), 0);
                last_strt = i;
                strt_cnt++;
                if (strt_cnt == N_IN && !expect_tmo) rdy_cyc = i + 5 + rdy_dly;
            end else if (strt_cnt > 0 && strt_cnt <= N_IN && i - last_strt >= 1 && i - last_strt <= 4) begin
                chk("din_hold", 32'(l4_din), 32'(mem[strt_cnt - 1]));
            end
            if (o_vld) begin
                if (prev_hold) begin
                    chk("hold_data", 32'(o_data), 32'(prev_data));
                    chk("hold_idx", 32'(o_idx), 32'(prev_idx));
                end
                if (o_rdy) begin
                    chk("o_idx", 32'(o_idx), 32'(beats));
                    if (beats < 64) chk("o_data", 32'(o_data), 32'(res[beats]));
                    beats++;
                end
            end
            prev_hold = o_vld && !o_rdy;
            prev_data = o_data;
            prev_idx = o_idx;
            if (l4_tx_done) begin
                tx_cnt++;
                tx_cyc = i;
                chk("busy_at_tx", 32'(busy), 1);
            end
            if (tx_cyc >= 0 && i == tx_cyc + 1) begin
                chk("busy_after_tx", 32'(busy), 0);
                break;
            end

            @(posedge clk); #1;
            go = (spam && strt_cnt > 0 && tx_cnt == 0 && $urandom_range(0, 7) == 0);
            src_rdata = (rd_s && addr_s < N_IN) ? mem[addr_s] : 18'($urandom);
            l4_rdy = (rdy_cyc >= 0 && i + 1 == rdy_cyc);
            g = i - rdy_cyc;
            for (int n = 0; n < 16; n++)
                l4_dout[n] = (rdy_cyc >= 0 && g >= 0 && g <= 3) ? res[g * 16 + n] : 18'($urandom);
            case (rdy_mode)
                0: o_rdy = 1'b1;
                1: o_rdy = ~o_rdy;
                default: o_rdy = 1'($urandom_range(0, 1));
            endcase
            if (abort_at > 0 && strt_cnt == abort_at) begin
                rst_n = 1'b0;
                aborted = 1'b1;
                break;
            end
        end

        go = 1'b0;
        l4_rdy = 1'b0;
        if (aborted) begin
            @(negedge clk);
            chk_reset_outputs();
            chk("abort_tx_count", 32'(tx_cnt), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            chk("finished", 32'(tx_cyc >= 0), 1);
            chk("strt_count", 32'(strt_cnt), 32'(N_IN));
            chk("beat_count", 32'(beats), expect_tmo ? 0 : 64);
            chk("tx_count", 32'(tx_cnt), 1);
            if (expect_tmo) begin
                chk("tmo_err", 32'(err), 1);
                chk("tmo_cycles", 32'(tx_cyc - last_strt), 260);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_vld", 32'(o_vld), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(0, 0, 1'b0, 0, 1'b1, 1'b0);
        run($urandom_range(0, 20), 1, 1'b0, 0, 1'b0, 1'b0);
        run($urandom_range(0, 20), 2, 1'b1, 0, 1'b0, 1'b0);
        run(3, 1, 1'b1, 0, 1'b1, 1'b0);
        run(0, 0, 1'b0, 50, 1'b1, 1'b0);
        run(2, 0, 1'b0, 0, 1'b1, 1'b0);
`ifdef L4_SEQ_TIMEOUT_EN
        run(0, 0, 1'b0, 0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
